// File: rtl/regfile_pkg.sv
// Shared constants and default-configuration port typedefs for the multi-port register file.
// Latency: none (package). Backpressure: none.
// Wrappers built at the default geometry use the typedefs; other geometries size ports from parameters.
package regfile_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_NUM_RD = 2;
    localparam int DEFAULT_NUM_WR = 1;
    localparam int DEFAULT_AW     = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_WIDTH-1:0] word_t;
    typedef logic [DEFAULT_AW-1:0]    addr_t;

    typedef word_t [DEFAULT_NUM_RD-1:0] rd_data_t;
    typedef addr_t [DEFAULT_NUM_RD-1:0] rd_addr_t;
    typedef logic  [DEFAULT_NUM_RD-1:0] rd_flag_t;
    typedef word_t [DEFAULT_NUM_WR-1:0] wr_data_t;
    typedef addr_t [DEFAULT_NUM_WR-1:0] wr_addr_t;
    typedef logic  [DEFAULT_NUM_WR-1:0] wr_en_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits: reserve sets, any write clears, reserve wins on collision.
// Latency: busyR registered, 1 cycle. Backpressure: none, always accepts.
// Register 0 has no busy flop and always reports idle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    parameter int NUM_WR = DEFAULT_NUM_WR,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    regW,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_reg,
    input  logic [NUM_RD-1:0][AW-1:0]    regR,
    output logic [NUM_RD-1:0]            busyR
);

    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:0] busy_cur;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] set_vec;
    logic [NUM_RD-1:0] busy_rd;

    assign busy_cur = {busy_q, 1'b0};

    // Set is OR-ed after the clear so a same-edge reserve beats the write.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                clr_vec[regW[p]] = 1'b1;
            end
        end
        if (rsv_en) begin
            set_vec[rsv_reg] = 1'b1;
        end
        busy_nxt    = (busy_cur & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        busy_rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy_rd[i] = (BYPASS != 0) ? busy_nxt[regR[i]] : busy_cur[regR[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            busyR  <= '0;
        end else begin
            busy_q <= busy_nxt[DEPTH-1:1];
            busyR  <= busy_rd;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port flop register file, reg0 hardwired to zero, optional write-to-read forwarding.
// Latency: reads registered, 1 cycle after address sampled. Backpressure: none, all ports accept every cycle.
// Same-register writes resolve to the highest write port index.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    parameter int NUM_WR = DEFAULT_NUM_WR,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    regW,
    input  logic [NUM_WR-1:0][WIDTH-1:0] portW,
    input  logic [NUM_RD-1:0][AW-1:0]    regR,
    output logic [NUM_RD-1:0][WIDTH-1:0] portR,
    output logic [NUM_RD-1:0]            busyR,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_reg
);

    logic [WIDTH-1:0] mem     [1:DEPTH-1];
    logic [WIDTH-1:0] rf_view [DEPTH];
    logic [WIDTH-1:0] wr_dat  [DEPTH];
    logic [DEPTH-1:0] wr_hit;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_nxt;

    // Later ports overwrite earlier ones, giving highest-index priority.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_dat[r] = '0;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (regW[p] != '0)) begin
                wr_hit[regW[p]] = 1'b1;
                wr_dat[regW[p]] = portW[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (wr_hit[r]) begin
                    mem[r] <= wr_dat[r];
                end
            end
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int r = 1; r < DEPTH; r++) begin
            rf_view[r] = mem[r];
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if ((BYPASS != 0) && wr_hit[regR[i]]) begin
                rd_nxt[i] = wr_dat[regR[i]];
            end else begin
                rd_nxt[i] = rf_view[regR[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            portR <= '0;
        end else begin
            portR <= rd_nxt;
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .regW    (regW),
        .rsv_en  (rsv_en),
        .rsv_reg (rsv_reg),
        .regR    (regR),
        .busyR   (busyR)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a BYPASS=1 and a BYPASS=0 register file with identical stimulus and scoreboards both
// against an array-plus-busy-bit reference model.
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NW-1:0]         wr_en;
    logic [NW-1:0][AW-1:0] regW;
    logic [NW-1:0][W-1:0]  portW;
    logic [NR-1:0][AW-1:0] regR;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_reg;
    logic [NR-1:0][W-1:0]  portR_b1, portR_b0;
    logic [NR-1:0]         busyR_b1, busyR_b0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .regW(regW), .portW(portW), .regR(regR),
        .portR(portR_b1), .busyR(busyR_b1), .rsv_en(rsv_en), .rsv_reg(rsv_reg)
    );

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .regW(regW), .portW(portW), .regR(regR),
        .portR(portR_b0), .busyR(busyR_b0), .rsv_en(rsv_en), .rsv_reg(rsv_reg)
    );

    typedef struct {
        logic [NR-1:0][W-1:0] p1;
        logic [NR-1:0][W-1:0] p0;
        logic [NR-1:0]        b1;
        logic [NR-1:0]        b0;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    logic [W-1:0] ref_mem  [D];
    bit           ref_busy [D];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: apply this edge's operations to an array, then pick pre- or post-edge view.
    task automatic step(input string nm);
        exp_t         e;
        logic [W-1:0] new_mem  [D];
        bit           new_busy [D];
        if (rst) begin
            e.p1 = '0; e.p0 = '0; e.b1 = '0; e.b0 = '0;
            for (int r = 0; r < D; r++) begin
                ref_mem[r]  = '0;
                ref_busy[r] = 1'b0;
            end
        end else begin
            new_mem  = ref_mem;
            new_busy = ref_busy;
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p]) begin
                    if (regW[p] != 0) new_mem[regW[p]] = portW[p];
                    new_busy[regW[p]] = 1'b0;
                end
            end
            if (rsv_en && rsv_reg != 0) new_busy[rsv_reg] = 1'b1;
            for (int i = 0; i < NR; i++) begin
                e.p1[i] = new_mem[regR[i]];
                e.p0[i] = ref_mem[regR[i]];
                e.b1[i] = new_busy[regR[i]];
                e.b0[i] = ref_busy[regR[i]];
            end
            ref_mem  = new_mem;
            ref_busy = new_busy;
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; regW = '0; portW = '0; regR = '0; rsv_en = 1'b0; rsv_reg = '0;
    endtask

    exp_t  m_e;
    string m_nm;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                m_e  = exp_q.pop_front();
                m_nm = name_q.pop_front();
                for (int i = 0; i < NR; i++) begin
                    check($sformatf("%s b1.portR[%0d]", m_nm, i), portR_b1[i], m_e.p1[i]);
                    check($sformatf("%s b0.portR[%0d]", m_nm, i), portR_b0[i], m_e.p0[i]);
                    check($sformatf("%s b1.busyR[%0d]", m_nm, i), {31'b0, busyR_b1[i]}, {31'b0, m_e.b1[i]});
                    check($sformatf("%s b0.busyR[%0d]", m_nm, i), {31'b0, busyR_b0[i]}, {31'b0, m_e.b0[i]});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected end before 2000000");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        for (int r = 0; r < D; r++) begin
            ref_mem[r]  = '0;
            ref_busy[r] = 1'b0;
        end

        // Reset with a write pending: write must be discarded.
        wr_en = 2'b01; regW[0] = 4'd3; portW[0] = 32'hDEADBEEF; regR = {NR{4'd3}};
        for (int c = 0; c < 5; c++) step("reset");
        rst = 1'b0;
        idle(); regR = {NR{4'd3}};
        step("post_reset_rd3");

        // Register 0 ignores writes and reserves.
        idle(); wr_en = 2'b01; regW[0] = 4'd0; portW[0] = 32'h12345678; rsv_en = 1'b1; rsv_reg = 4'd0;
        step("reg0_write");
        idle(); step("reg0_read");

        // Forwarding versus pre-write view.
        idle(); wr_en = 2'b01; regW[0] = 4'd5; portW[0] = 32'h11111111; step("r5_init");
        idle(); wr_en = 2'b10; regW[1] = 4'd5; portW[1] = 32'h22222222; regR[0] = 4'd5;
        step("r5_bypass");
        idle(); regR[0] = 4'd5; step("r5_after");

        // Dual write to one register: port 1 wins.
        idle(); wr_en = 2'b11; regW[0] = 4'd7; regW[1] = 4'd7;
        portW[0] = 32'hAAAA0000; portW[1] = 32'h0000BBBB; regR[1] = 4'd7; regR[2] = 4'd7;
        step("r7_dual");
        idle(); regR[1] = 4'd7; step("r7_read");

        // Busy lifecycle on register 9.
        idle(); rsv_en = 1'b1; rsv_reg = 4'd9; regR = {NR{4'd9}}; step("r9_rsv");
        idle(); rsv_en = 1'b1; rsv_reg = 4'd9; regR = {NR{4'd9}}; step("r9_rsv_again");
        idle(); regR = {NR{4'd9}}; step("r9_hold");
        idle(); wr_en = 2'b01; regW[0] = 4'd9; portW[0] = 32'h00000099; regR = {NR{4'd9}};
        step("r9_write");
        idle(); wr_en = 2'b10; regW[1] = 4'd9; portW[1] = 32'h99990000;
        rsv_en = 1'b1; rsv_reg = 4'd9; regR = {NR{4'd9}};
        step("r9_rsv_and_write");
        idle(); regR = {NR{4'd9}}; step("r9_final");

        for (int c = 0; c < 10000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = NW'($urandom);
            rsv_en  = ($urandom_range(0, 2) == 0);
            rsv_reg = AW'($urandom);
            for (int p = 0; p < NW; p++) begin
                regW[p]  = AW'($urandom);
                portW[p] = $urandom;
            end
            for (int i = 0; i < NR; i++) begin
                regR[i] = ($urandom_range(0, 3) == 0) ? regW[$urandom_range(0, NW-1)] : AW'($urandom);
            end
            step("random");
        end
        rst = 1'b0;
        idle();

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
